// File: rtl/input_unloader_if.sv
// Byte-stream input and reassembled-frame output bundle for input_unloader.
// master drives the stream and observes frames; slave is the unloader itself.
interface input_unloader_if #(
  parameter int W = 32
);
  logic         ena;
  logic [7:0]   in_byte;
  logic         busy;
  logic         valid;
  logic         frame_err;
  logic [W-1:0] word_a;
  logic [W-1:0] word_b;
  logic [2:0]   mode_out;

  modport master (
    output ena, in_byte,
    input  busy, valid, frame_err, word_a, word_b, mode_out
  );

  modport slave (
    input  ena, in_byte,
    output busy, valid, frame_err, word_a, word_b, mode_out
  );
endinterface

// File: rtl/input_unloader.sv
// Reassembles two W-bit words (A then B, MSB nibble first) plus a 3-bit mode
// from a nibble-serial byte stream; flags frames broken by gaps or mode changes.
module input_unloader #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input_unloader_if.slave   bus
);
  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [W-1:0]   shift_reg, shift_next, hold_a;
  logic [2:0]     mode_cap;
  logic [W-1:0]   word_a_r, word_b_r;
  logic [2:0]     mode_out_r;
  logic           valid_r, frame_err_r;

  logic           shift_en, cap_mode, load_hold, commit, abort;
  logic           rdy;
  logic [2:0]     mode_in;
  logic [3:0]     nib;

  assign mode_in    = bus.in_byte[7:5];
  assign rdy        = bus.in_byte[4];
  assign nib        = bus.in_byte[3:0];
  assign shift_next = (shift_reg << 4) | W'(nib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A byte whose mode differs from the captured one aborts the frame and is
  // discarded, even though its rdy bit would otherwise start a new frame.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    cap_mode   = 1'b0;
    load_hold  = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    if (bus.ena) begin
      case (state)
        IDLE: begin
          if (rdy) begin
            cap_mode = 1'b1;
            shift_en = 1'b1;
            if (NIB == 1) begin
              load_hold  = 1'b1;
              cnt_next   = '0;
              state_next = RECV_B;
            end else begin
              cnt_next   = CW'(1);
              state_next = RECV_A;
            end
          end
        end
        RECV_A, RECV_B: begin
          if (rdy && (mode_in == mode_cap)) begin
            shift_en = 1'b1;
            if (cnt == LAST) begin
              cnt_next = '0;
              if (state == RECV_A) begin
                load_hold  = 1'b1;
                state_next = RECV_B;
              end else begin
                commit     = 1'b1;
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end else begin
            abort      = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Pulses default low every edge so they last exactly one cycle regardless of ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      hold_a      <= '0;
      mode_cap    <= '0;
      word_a_r    <= '0;
      word_b_r    <= '0;
      mode_out_r  <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      valid_r     <= commit;
      frame_err_r <= abort;
      if (shift_en)  shift_reg <= shift_next;
      if (cap_mode)  mode_cap  <= mode_in;
      if (load_hold) hold_a    <= shift_next;
      if (commit) begin
        word_a_r   <= hold_a;
        word_b_r   <= shift_next;
        mode_out_r <= mode_cap;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.word_a    = word_a_r;
  assign bus.word_b    = word_b_r;
  assign bus.mode_out  = mode_out_r;
endmodule

// File: tb/tb_input_unloader.sv
// Directed self-checking bench for input_unloader (W=32): good frames, stalls,
// gap and mode-change aborts, back-to-back frames and mid-frame reset.
module tb_input_unloader;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  input_unloader_if #(.W(32)) bus ();

  input_unloader #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one byte, let the next rising edge sample it, then settle 1ns past the edge.
  task automatic applyStimulus(input logic e, input logic [7:0] b);
    bus.ena     = e;
    bus.in_byte = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWords(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] m);
    checkOutput({tag, "_word_a"}, 64'(bus.word_a), 64'(a));
    checkOutput({tag, "_word_b"}, 64'(bus.word_b), 64'(b));
    checkOutput({tag, "_mode"}, 64'(bus.mode_out), 64'(m));
  endtask

  // Sends the first nBytes of frame {a,b} in mode m; 3 stall cycles follow bytes stallA/stallB.
  task automatic sendFrame(input string tag, input logic [2:0] m,
                           input logic [31:0] a, input logic [31:0] b,
                           input int stallA, input int stallB, input int nBytes);
    logic [63:0] ab;
    logic [3:0]  nib;
    ab = {a, b};
    for (int k = 1; k <= nBytes; k++) begin
      nib = ab[63-4*(k-1) -: 4];
      applyStimulus(1'b1, {m, 1'b1, nib});
      checkOutput({tag, "_err"}, 64'(bus.frame_err), 64'd0);
      if (k < 16) begin
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
        checkOutput({tag, "_valid"}, 64'(bus.valid), 64'd0);
      end else begin
        checkOutput({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_valid_end"}, 64'(bus.valid), 64'd1);
        checkWords(tag, a, b, m);
      end
      if (k == stallA || k == stallB) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(1'b0, 8'h00);
          checkOutput({tag, "_stall_busy"}, 64'(bus.busy), 64'd1);
          checkOutput({tag, "_stall_valid"}, 64'(bus.valid), 64'd0);
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.ena     = 1'b0;
    bus.in_byte = 8'h00;
    #2;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_valid", 64'(bus.valid), 64'd0);
    checkOutput("rst_err", 64'(bus.frame_err), 64'd0);
    checkWords("rst", 32'h0, 32'h0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic frame");
    sendFrame("f1", 3'd5, 32'h12345678, 32'h9ABCDEF0, 0, 0, 16);
    applyStimulus(1'b1, 8'h00);
    checkOutput("f1_tail_valid", 64'(bus.valid), 64'd0);
    checkOutput("f1_tail_err", 64'(bus.frame_err), 64'd0);
    checkOutput("f1_tail_busy", 64'(bus.busy), 64'd0);

    $display("[TB] stalled frame");
    sendFrame("f2", 3'd5, 32'h12345678, 32'h9ABCDEF0, 5, 12, 16);
    applyStimulus(1'b1, 8'h00);
    checkOutput("f2_tail_valid", 64'(bus.valid), 64'd0);

    $display("[TB] gap abort after 10 bytes");
    sendFrame("g", 3'd5, 32'h12345678, 32'h9ABCDEF0, 0, 0, 10);
    applyStimulus(1'b1, 8'h00);
    checkOutput("gap_err", 64'(bus.frame_err), 64'd1);
    checkOutput("gap_busy", 64'(bus.busy), 64'd0);
    checkOutput("gap_valid", 64'(bus.valid), 64'd0);
    checkWords("gap", 32'h12345678, 32'h9ABCDEF0, 3'd5);
    applyStimulus(1'b0, 8'h00);
    checkOutput("gap_err_clear", 64'(bus.frame_err), 64'd0);

    $display("[TB] mode-change abort");
    applyStimulus(1'b1, 8'hB1);
    applyStimulus(1'b1, 8'hB2);
    applyStimulus(1'b1, 8'h73);
    checkOutput("mode_err", 64'(bus.frame_err), 64'd1);
    checkOutput("mode_busy", 64'(bus.busy), 64'd0);
    applyStimulus(1'b1, 8'h00);
    checkOutput("mode_err_clear", 64'(bus.frame_err), 64'd0);
    checkOutput("mode_no_start", 64'(bus.busy), 64'd0);
    checkWords("mode", 32'h12345678, 32'h9ABCDEF0, 3'd5);

    $display("[TB] back-to-back frames");
    sendFrame("b1", 3'd5, 32'h12345678, 32'h9ABCDEF0, 0, 0, 16);
    sendFrame("b2", 3'd2, 32'hFFFFFFFF, 32'h00000000, 0, 0, 16);
    applyStimulus(1'b1, 8'h00);
    checkOutput("b2_tail_valid", 64'(bus.valid), 64'd0);

    $display("[TB] mid-frame reset");
    sendFrame("r", 3'd5, 32'h12345678, 32'h9ABCDEF0, 0, 0, 8);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_err", 64'(bus.frame_err), 64'd0);
    checkWords("mid_rst", 32'h0, 32'h0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'h00);
    checkOutput("post_rst_err", 64'(bus.frame_err), 64'd0);
    checkOutput("post_rst_valid", 64'(bus.valid), 64'd0);
    sendFrame("r2", 3'd6, 32'hCAFEBABE, 32'h01234567, 0, 0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
